// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - shared XGMII constants, generator state type and PRBS31 step
//
// Purpose : character codes and idle word for the XGMII test-frame generator,
//           the generator FSM state enum and a 64-bit PRBS31 advance function.
// Ports   : none (package).
package xgmii_pkg;

   localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
   localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;

   localparam logic [7:0]  XGMII_START  = 8'hFB;
   localparam logic [7:0]  XGMII_TERM   = 8'hFD;
   localparam logic [7:0]  XGMII_IDLE   = 8'h07;
   localparam logic [7:0]  XGMII_PRE    = 8'h55;
   localparam logic [7:0]  XGMII_SFD    = 8'hD5;

   localparam logic [30:0] PRBS31_SEED  = 31'h7FFFFFFF;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      PRE,
      DATA,
      TERM,
      IFG
   } gen_state_t;

   typedef struct packed {
      logic [30:0] state;
      logic [63:0] data;
   } prbs_step_t;

   // x^31 + x^28 + 1, 64 serial steps; data bit j is the j-th generated bit,
   // so lane 0 carries the first eight bits, LSB first.
   function automatic prbs_step_t prbs31_step64(input logic [30:0] seed);
      prbs_step_t res;
      logic [30:0] st;
      st = seed;
      res.data = '0;
      for (int j = 0; j < 64; j++) begin
         res.data[j] = st[30] ^ st[27];
         st = {st[29:0], res.data[j]};
      end
      res.state = st;
      return res;
   endfunction

endpackage

// File: rtl/xgmii_frame_gen_if.sv
// rtl/xgmii_frame_gen_if.sv - control and XGMII output bundle of the frame generator
//
// Purpose : groups the generator's control inputs and its XGMII/status outputs.
// Ports   : master drives enable/start/tx_ready/frame_len/ifg_words/frame_count
//           and observes xgmii_txd/xgmii_txc/busy/done/frames_sent;
//           slave (the generator) is the mirror image.
interface xgmii_frame_gen_if #(
   parameter int SEQ_WIDTH = 32,
   parameter int LEN_WIDTH = 14
);
   logic                 enable;
   logic                 start;
   logic                 tx_ready;
   logic [LEN_WIDTH-1:0] frame_len;
   logic [7:0]           ifg_words;
   logic [SEQ_WIDTH-1:0] frame_count;
   logic [63:0]          xgmii_txd;
   logic [7:0]           xgmii_txc;
   logic                 busy;
   logic                 done;
   logic [SEQ_WIDTH-1:0] frames_sent;

   modport master (
      output enable, start, tx_ready, frame_len, ifg_words, frame_count,
      input  xgmii_txd, xgmii_txc, busy, done, frames_sent
   );

   modport slave (
      input  enable, start, tx_ready, frame_len, ifg_words, frame_count,
      output xgmii_txd, xgmii_txc, busy, done, frames_sent
   );
endinterface

// File: rtl/xgmii_term_mux.sv
// rtl/xgmii_term_mux.sv - merges trailing data lanes with the terminate character
//
// Purpose : builds the final XGMII word of a frame: lanes below rem keep data,
//           lane rem carries FD, higher lanes carry idle 07.
// Ports   : data [63:0] in  - payload word for the final position
//           rem  [2:0]  in  - number of data lanes in the final word
//           txd  [63:0] out - merged terminate word
//           txc  [7:0]  out - control flags (8'hFF << rem)
module xgmii_term_mux
   import xgmii_pkg::*;
(
   input  logic [63:0] data,
   input  logic [2:0]  rem,
   output logic [63:0] txd,
   output logic [7:0]  txc
);

   always_comb begin
      txd = '0;
      txc = '0;
      for (int i = 0; i < 8; i++) begin
         if (3'(i) < rem) begin
            txd[8*i +: 8] = data[8*i +: 8];
         end else if (3'(i) == rem) begin
            txd[8*i +: 8] = XGMII_TERM;
            txc[i]        = 1'b1;
         end else begin
            txd[8*i +: 8] = XGMII_IDLE;
            txc[i]        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xgmii_frame_gen.sv
// rtl/xgmii_frame_gen.sv - XGMII test-frame generator for 10GBASE-R link tests
//
// Purpose : emits bursts of start/preamble, sequence-numbered payload and
//           terminate words separated by idle gaps. Build option XGEN_PRBS_EN
//           replaces the incrementing payload with a PRBS31 pattern.
// Ports   : clk    in - core clock
//           rst_n  in - asynchronous active-low reset
//           gen_if     - slave side of xgmii_frame_gen_if (control in,
//                        xgmii_txd/xgmii_txc/busy/done/frames_sent out)
module xgmii_frame_gen
   import xgmii_pkg::*;
#(
   parameter int SEQ_WIDTH = 32,
   parameter int LEN_WIDTH = 14,
   parameter int MIN_LEN   = 8
)(
   input  logic        clk,
   input  logic        rst_n,
   xgmii_frame_gen_if.slave gen_if
);

   gen_state_t           state;
   gen_state_t           next_state;

   logic [7:0]           ifg_lat;
   logic [7:0]           ifg_cnt;
   logic [SEQ_WIDTH-1:0] fc_lat;
   logic [SEQ_WIDTH-1:0] burst_cnt;
   logic [SEQ_WIDTH-1:0] seq;
   logic [SEQ_WIDTH-1:0] frames_sent_q;
   logic [LEN_WIDTH-1:0] len_lat;
   logic [LEN_WIDTH-1:0] len_clamped;
   logic [LEN_WIDTH-1:0] w_cnt;
   logic [LEN_WIDTH-1:0] word_idx;
   logic [LEN_WIDTH-1:0] last_full;
   logic [31:0]          seq_b;
   logic [63:0]          fill_word;
   logic [63:0]          payload;
   logic [63:0]          term_d;
   logic [7:0]           term_c;
   logic [63:0]          nxt_d;
   logic [7:0]           nxt_c;
   logic [63:0]          txd_q;
   logic [7:0]           txc_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 burst_done;
   logic                 ifg_last;

   // Outputs are registered from next_state, so w_cnt tracks the index of
   // the word currently on the bus and word_idx is the one being prepared.
   assign word_idx    = (state == PRE) ? '0 : w_cnt + LEN_WIDTH'(1);
   assign last_full   = (len_lat >> 3) - LEN_WIDTH'(1);
   assign len_clamped = (gen_if.frame_len < LEN_WIDTH'(MIN_LEN)) ?
                        LEN_WIDTH'(MIN_LEN) : gen_if.frame_len;
   assign burst_done  = (fc_lat != '0) && (burst_cnt == fc_lat);
   assign ifg_last    = (ifg_cnt == ifg_lat);
   assign seq_b       = 32'(seq);

`ifdef XGEN_PRBS_EN
   logic [30:0] lfsr;
   prbs_step_t  prbs_nxt;

   assign prbs_nxt  = prbs31_step64(lfsr);
   assign fill_word = prbs_nxt.data;

   // Reseeded every preamble, advanced once per DATA word, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= PRBS31_SEED;
      end else if (next_state == PRE) begin
         lfsr <= PRBS31_SEED;
      end else if (next_state == DATA) begin
         lfsr <= prbs_nxt.state;
      end
   end
`else
   always_comb begin
      fill_word = '0;
      for (int i = 0; i < 8; i++) begin
         fill_word[8*i +: 8] = {word_idx[4:0], 3'(i)};
      end
   end
`endif

   // Bytes 0-3 of the first data word carry the sequence number.
   always_comb begin
      payload = fill_word;
      if (word_idx == '0) begin
         payload[31:0] = seq_b;
      end
   end

   xgmii_term_mux u_term_mux (
      .data (payload),
      .rem  (len_lat[2:0]),
      .txd  (term_d),
      .txc  (term_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (gen_if.start && gen_if.enable) begin
               next_state = gen_if.tx_ready ? PRE : WAIT;
            end
         end
         WAIT: begin
            if (gen_if.tx_ready) begin
               next_state = PRE;
            end
         end
         PRE:  next_state = DATA;
         DATA: begin
            if (w_cnt == last_full) begin
               next_state = TERM;
            end
         end
         TERM: next_state = IFG;
         IFG: begin
            if (ifg_last) begin
               if (burst_done || !gen_if.enable) begin
                  next_state = IDLE;
               end else if (!gen_if.tx_ready) begin
                  next_state = WAIT;
               end else begin
                  next_state = PRE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      nxt_d = XGMII_IDLE_D;
      nxt_c = XGMII_IDLE_C;
      case (next_state)
         PRE: begin
            nxt_d = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};
            nxt_c = 8'h01;
         end
         DATA: begin
            nxt_d = payload;
            nxt_c = 8'h00;
         end
         TERM: begin
            nxt_d = term_d;
            nxt_c = term_c;
         end
         default: begin
            nxt_d = XGMII_IDLE_D;
            nxt_c = XGMII_IDLE_C;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifg_lat       <= 8'd1;
         ifg_cnt       <= 8'd0;
         fc_lat        <= '0;
         burst_cnt     <= '0;
         seq           <= '0;
         frames_sent_q <= '0;
         len_lat       <= LEN_WIDTH'(MIN_LEN);
         w_cnt         <= '0;
      end else begin
         if (state == IDLE && next_state != IDLE) begin
            ifg_lat   <= (gen_if.ifg_words == 8'd0) ? 8'd1 : gen_if.ifg_words;
            fc_lat    <= gen_if.frame_count;
            burst_cnt <= '0;
         end
         if (next_state == PRE) begin
            len_lat <= len_clamped;
         end
         if (next_state == DATA || next_state == TERM) begin
            w_cnt <= word_idx;
         end
         if (state == TERM) begin
            seq           <= seq + 1'b1;
            frames_sent_q <= frames_sent_q + 1'b1;
            burst_cnt     <= burst_cnt + 1'b1;
            ifg_cnt       <= 8'd1;
         end else if (state == IFG) begin
            ifg_cnt <= ifg_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txd_q  <= XGMII_IDLE_D;
         txc_q  <= XGMII_IDLE_C;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         txd_q  <= nxt_d;
         txc_q  <= nxt_c;
         busy_q <= (next_state != IDLE);
         done_q <= (state == IFG) && (next_state == IDLE);
      end
   end

   assign gen_if.xgmii_txd   = txd_q;
   assign gen_if.xgmii_txc   = txc_q;
   assign gen_if.busy        = busy_q;
   assign gen_if.done        = done_q;
   assign gen_if.frames_sent = frames_sent_q;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// tb/tb_xgmii_frame_gen.sv - scoreboard bench for xgmii_frame_gen
module tb_xgmii_frame_gen;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  c;
      logic        busy;
      logic        done;
   } exp_t;

   localparam logic [63:0] IDLE_W = 64'h0707070707070707;
   localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   xgmii_frame_gen_if #(.SEQ_WIDTH(32), .LEN_WIDTH(14)) gif ();

   xgmii_frame_gen dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .gen_if (gif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("txd",  gif.xgmii_txd, mon_e.d);
         chk("txc",  64'(gif.xgmii_txc), 64'(mon_e.c));
         chk("busy", 64'(gif.busy), 64'(mon_e.busy));
         chk("done", 64'(gif.done), 64'(mon_e.done));
      end
   end

   task automatic push(input logic [63:0] d, input logic [7:0] c, input logic b, input logic dn);
      exp_t e;
      e.d = d; e.c = c; e.busy = b; e.done = dn;
      sb.push_back(e);
   endtask

   function automatic logic [7:0] pbyte(input int k, input int sq);
      logic [31:0] s;
      logic [31:0] kk;
      s  = sq;
      kk = k;
      if (k < 4) return s[8*k +: 8];
      return kk[7:0];
   endfunction

   // Expected words from PRE through the inter-frame gap; a final frame
   // also gets the done/idle word and one quiet idle word.
   task automatic push_frame(input int len, input int sq, input int ifg, input bit last);
      int L;
      int r;
      int w;
      logic [63:0] d;
      logic [7:0]  c;
      L = (len < 8) ? 8 : len;
      push(PRE_W, 8'h01, 1'b1, 1'b0);
      for (int wi = 0; wi < L / 8; wi++) begin
         d = '0;
         for (int i = 0; i < 8; i++) d[8*i +: 8] = pbyte(8*wi + i, sq);
         push(d, 8'h00, 1'b1, 1'b0);
      end
      r = L % 8;
      w = L / 8;
      d = '0;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < r) d[8*i +: 8] = pbyte(8*w + i, sq);
         else if (i == r) begin d[8*i +: 8] = 8'hFD; c[i] = 1'b1; end
         else begin d[8*i +: 8] = 8'h07; c[i] = 1'b1; end
      end
      push(d, c, 1'b1, 1'b0);
      for (int i = 0; i < ((ifg == 0) ? 1 : ifg); i++) push(IDLE_W, 8'hFF, 1'b1, 1'b0);
      if (last) begin
         push(IDLE_W, 8'hFF, 1'b0, 1'b1);
         push(IDLE_W, 8'hFF, 1'b0, 1'b0);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", 64'(sb.size()), 64'd0);
      sb.delete();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      gif.enable = 1'b1; gif.start = 1'b0; gif.tx_ready = 1'b1;
      gif.frame_len = 14'd16; gif.ifg_words = 8'd2; gif.frame_count = 32'd1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Leaves the bench in the cycle after the start pulse.
   task automatic pulse_start(input int len, input int ifg, input int fc);
      gif.frame_len = 14'(len); gif.ifg_words = 8'(ifg); gif.frame_count = 32'(fc);
      gif.start = 1'b1;
      @(posedge clk);
      #1 gif.start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      gif.enable = 1'b1; gif.start = 1'b0; gif.tx_ready = 1'b1;
      gif.frame_len = 14'd16; gif.ifg_words = 8'd2; gif.frame_count = 32'd1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      chk("rst_txd",  gif.xgmii_txd, IDLE_W);
      chk("rst_txc",  64'(gif.xgmii_txc), 64'hFF);
      chk("rst_busy", 64'(gif.busy), 64'd0);
      chk("rst_done", 64'(gif.done), 64'd0);
      chk("rst_sent", 64'(gif.frames_sent), 64'd0);

      // idle after reset, no start
      do_reset();
      for (int i = 0; i < 6; i++) push(IDLE_W, 8'hFF, 1'b0, 1'b0);
      drain();
      chk("idle_sent", 64'(gif.frames_sent), 64'd0);

      // single 16-byte frame
      do_reset();
      push(IDLE_W, 8'hFF, 1'b0, 1'b0);
      push_frame(16, 0, 2, 1);
      pulse_start(16, 2, 1);
      drain();
      chk("f16_sent", 64'(gif.frames_sent), 64'd1);

      // three 13-byte frames, ifg 0 treated as 1
      do_reset();
      push(IDLE_W, 8'hFF, 1'b0, 1'b0);
      for (int f = 0; f < 3; f++) push_frame(13, f, 0, f == 2);
      pulse_start(13, 0, 3);
      drain();
      chk("f13_sent", 64'(gif.frames_sent), 64'd3);

      // short length clamped to 8
      do_reset();
      push(IDLE_W, 8'hFF, 1'b0, 1'b0);
      push_frame(3, 0, 3, 1);
      pulse_start(3, 3, 1);
      drain();
      chk("f3_sent", 64'(gif.frames_sent), 64'd1);

      // continuous mode, enable dropped during second frame's DATA
      do_reset();
      push(IDLE_W, 8'hFF, 1'b0, 1'b0);
      push_frame(40, 0, 2, 0);
      push_frame(40, 1, 2, 1);
      pulse_start(40, 2, 0);
      repeat (11) @(posedge clk);
      #1 gif.enable = 1'b0;
      drain();
      chk("cont_sent", 64'(gif.frames_sent), 64'd2);

      // tx_ready low at start, dropped mid-frame, low at end of gap
      do_reset();
      gif.tx_ready = 1'b0;
      push(IDLE_W, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push(IDLE_W, 8'hFF, 1'b1, 1'b0);
      push_frame(32, 0, 1, 0);
      for (int i = 0; i < 3; i++) push(IDLE_W, 8'hFF, 1'b1, 1'b0);
      push_frame(32, 1, 1, 1);
      pulse_start(32, 1, 2);
      repeat (3) @(posedge clk);
      #1 gif.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 gif.tx_ready = 1'b0;
      repeat (7) @(posedge clk);
      #1 gif.tx_ready = 1'b1;
      drain();
      chk("rdy_sent", 64'(gif.frames_sent), 64'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1);
   end

endmodule

// File: doc/xgmii_frame_gen.md
Name: xgmii_frame_gen

Overview:
- Transmit-side XGMII test-frame generator feeding the 64-bit xgmii_txd/xgmii_txc input of a 10GBASE-R PCS/PMA core, clocked by the core's coreclk.
- Replaces constant idle transmission in the SFP link tests: emits start/preamble, sequence-numbered payload and terminate, separated by idle gaps.
- The far-end receive monitors (non-idle counters, captured XGMII words) count and inspect these frames.

Parameters:
- SEQ_WIDTH, 32, width of the frame sequence number and of frames_sent.
- LEN_WIDTH, 14, width of frame_len (payload bytes after SFD).
- MIN_LEN, 8, minimum payload byte count; smaller requests are clamped to this.

Ports:
- clk  in  1  core clock (coreclk, 156.25 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; generator may run while high
- start  in  1  pulse; begins a burst when idle
- tx_ready  in  1  link ready (PCS core_status[0]); a frame starts only while high
- frame_len  in  LEN_WIDTH  payload bytes per frame, latched at each frame start
- ifg_words  in  8  idle words between frames, 0 treated as 1, latched at burst start
- frame_count  in  SEQ_WIDTH  frames per burst; 0 means continuous until enable falls
- xgmii_txd  out  64  XGMII data; lane i is bits [8i+7:8i]
- xgmii_txc  out  8  XGMII control; bit i corresponds to lane i
- busy  out  1  high from burst accept until return to IDLE
- done  out  1  one-cycle pulse when a burst ends
- frames_sent  out  SEQ_WIDTH  frames fully emitted since reset; wraps

Behaviour:
- Clock and reset: single clock, reset is asynchronous and active-low. All outputs are registered.
- Reset values: xgmii_txd=64'h0707070707070707, xgmii_txc=8'hFF, busy=0, done=0, frames_sent=0, seq=0, state=IDLE.
- IDLE state:
  - Outputs are the idle word.
  - On start && enable: latch ifg_words and frame_count, clear the burst counter, set busy.
  - Then go to PRE if tx_ready, else WAIT.
  - start is ignored while busy.
- WAIT state: outputs idle; go to PRE when tx_ready rises.
- PRE state:
  - Latch L = max(frame_len, MIN_LEN).
  - Emit d=64'hD5555555555555FB, c=8'h01 (lane0 FB; lanes 1-6 are 55; lane7 D5).
  - Latency: start sampled in cycle N gives PRE on the outputs in cycle N+1 (tx_ready high).
- DATA state:
  - Payload byte k (k=0..L-1) is placed in lane k%8 of data word k/8, with c=0 for full words.
  - Bytes 0-3 carry seq, little-endian.
  - Bytes k>=4 carry k[7:0] (default payload).
- Final word, with r = L%8:
  - r != 0: the last word holds r data lanes (0..r-1), lane r=FD, lanes above r =07, c = 8'hFF << r.
  - r == 0: the word after the last full data word is d=64'h07070707070707FD, c=8'hFF.
- After the terminate word:
  - frames_sent++ and seq++ in the same cycle.
  - Go to IFG and emit idle words for max(ifg_words,1) cycles.
- IFG exit, in priority order:
  - burst complete (frame_count!=0 and burst counter == frame_count), or enable low: go IDLE, pulse done, clear busy.
  - tx_ready low: go WAIT.
  - otherwise: go PRE.
- Mid-frame events:
  - enable low or tx_ready low mid-frame does not truncate the frame; it completes, then the exit rules above apply.
  - frame_len changes mid-frame have no effect.
- Counter wrap: seq and frames_sent wrap at 2^SEQ_WIDTH. The continuous-mode burst counter also wraps.

Optional Feature:
- Macro: XGEN_PRBS_EN.
- Defined: payload bytes k>=4 come from a PRBS31 generator (x^31+x^28+1) advanced 64 bits per DATA word. It is seeded to 31'h7FFFFFFF at each PRE, so every frame's payload is identical apart from the seq bytes. The LFSR state holds during non-DATA cycles.
- Undefined: incrementing k[7:0] payload; no LFSR logic is synthesised.

Decomposition:
- Package xgmii_pkg holds:
  - XGMII_IDLE_D and XGMII_IDLE_C
  - XGMII_START 8'hFB, XGMII_TERM 8'hFD, XGMII_IDLE 8'h07, XGMII_PRE 8'h55, XGMII_SFD 8'hD5
  - the gen_state_t enum {IDLE, WAIT, PRE, DATA, TERM, IFG}
- Sub-module xgmii_term_mux (combinational): takes a data word and r, returns the lane-merged terminate word and its txc.
- The PRBS31 64-bit step is a function in xgmii_pkg.

Test Plan:
- Reset release with no start: txd=64'h0707070707070707 and txc=8'hFF every cycle; busy=0; frames_sent=0.
- frame_len=16, ifg_words=2, frame_count=1, start pulse:
  - PRE word, then 2 DATA words (first = 64'h0706050400000000, c=00), then 07..07FD/FF, then 2 idle words.
  - done pulses once; frames_sent=1.
- frame_len=13, frame_count=3:
  - each final word has lanes0-4 data, lane5 FD, lanes6-7 07, c=8'hE0.
  - seq bytes read 0,1,2; frames_sent=3.
- frame_len=3: clamped to 8 bytes (one full data word plus a separate FD word).
- frame_count=0, enable dropped mid-DATA: the current frame completes with terminate, then IDLE, and done pulses.
- tx_ready low at start: outputs stay idle in WAIT. tx_ready rises in cycle M: PRE appears in M+1. Dropping tx_ready during DATA still completes the frame.
